regfile_access_sequencer: RTL and testbench
===========================================

Name: regfile_access_sequencer

Overview:
- Initiator side of the single-port RV32I register file. That register file exposes one address, one write-data bus, one read/write operation bit and one read-data bus.
- Accepts one combined request per transaction: optional writeback of rd, then operand reads of rs1 and rs2. It serialises these onto the single port and returns both operands through a valid/ready response.
- Sits between decode/writeback logic and the register file.

Parameters:
- XLEN, 32, data width of register contents and of reg_address.
- REG_AW, 5, width of the rs1/rs2/rd index fields; the index is zero-extended to XLEN on reg_address.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  sequencer can accept a request; high only in IDLE.
- req_we  input  1  writeback requested.
- req_rd  input  REG_AW  writeback register index.
- req_wdata  input  XLEN  writeback data.
- req_rs1  input  REG_AW  first operand index.
- req_rs2  input  REG_AW  second operand index.
- rsp_valid  output  1  operands available.
- rsp_ready  input  1  consumer accepts operands.
- rsp_rs1_data  output  XLEN  operand 1 value.
- rsp_rs2_data  output  XLEN  operand 2 value.
- reg_address  output  XLEN  register file address.
- reg_input  output  XLEN  register file write data.
- reg_operation  output  1  0 = read, 1 = write.
- reg_output  input  XLEN  register file read data; combinational, valid in the same cycle as reg_address.

Behaviour:
- Reset values:
  - State: IDLE.
  - req_ready = 1, rsp_valid = 0.
  - rsp_rs1_data = rsp_rs2_data = 0.
  - reg_address = 0, reg_input = 0, reg_operation = 0.
- Reset is asynchronous and forces reg_operation to 0 immediately. A write in flight when reset asserts is not guaranteed to commit; pending reads and the response are discarded.
- States: IDLE, WRITE, READ1, READ2, RESP.
- IDLE:
  - req_ready = 1.
  - On req_valid && req_ready, latch all request fields.
  - Next state is the first required step, in the order WRITE, READ1, READ2, RESP.
- WRITE is required iff req_we = 1 and req_rd != 0. A write to x0 is dropped silently.
- READ1 is required iff req_rs1 != 0; otherwise rsp_rs1_data is loaded with 0 at acceptance.
- READ2 is required iff req_rs2 != 0; otherwise rsp_rs2_data is loaded with 0 at acceptance.
- WRITE:
  - reg_address = rd, reg_input = wdata, reg_operation = 1.
  - Lasts exactly 1 cycle.
- READ1 / READ2:
  - reg_address = rs1 / rs2, reg_operation = 0, reg_input = 0.
  - reg_output is captured into the rsp register at the end of the cycle.
  - Lasts exactly 1 cycle.
- Write occurs before reads, so a read of rd in the same request returns req_wdata.
- RESP:
  - rsp_valid = 1; rsp data is held stable until rsp_ready.
  - On rsp_ready, return to IDLE.
  - No new request is accepted in the same cycle; req_ready rises the following cycle.
- In IDLE and RESP: reg_address = 0, reg_operation = 0, reg_input = 0.
- Latency from acceptance to rsp_valid = 1 + number of required access steps:
  - Minimum 1 cycle (no write, rs1 = rs2 = 0).
  - Maximum 4 cycles.
- rsp_valid never asserts without a preceding accepted request. req_ready is 0 in every non-IDLE state.

Optional Feature:
- REGSEQ_DEDUP_EN defined: when rs1 == rs2 != 0, READ2 is skipped and the READ1 capture is written to both rsp registers. Latency drops by 1.
- REGSEQ_DEDUP_EN undefined: READ2 is always issued when rs2 != 0, even if it equals rs1.

Decomposition:
- Shared package regfile_pkg holds:
  - The state enum.
  - REG_READ = 1'b0 and REG_WRITE = 1'b1.
  - XLEN and REG_AW defaults.
  - The zero-register index constant.
- The block is a single module; no sub-module is needed. The register file itself is instantiated only in the bench and at the top level.

Test Plan:
- Write then read back: req_we = 1, rd = 5, wdata = 0xDEADBEEF, rs1 = 5, rs2 = 0.
  - WRITE cycle: reg_address = 5, reg_operation = 1.
  - Then READ1, then rsp_valid on cycle 3 with rs1_data = 0xDEADBEEF, rs2_data = 0.
- Write to x0 dropped: req_we = 1, rd = 0, wdata = 0x1234, rs1 = 0, rs2 = 0.
  - reg_operation never 1.
  - rsp_valid 1 cycle after accept, both data = 0.
- Two distinct reads: preload x3 = 7 and x4 = 9; request rs1 = 3, rs2 = 4, we = 0.
  - Addresses 3 then 4 on consecutive cycles.
  - Response 7/9 with latency 3.
- Response backpressure: hold rsp_ready = 0 for 5 cycles.
  - rsp_valid and data stay stable; req_ready stays 0.
  - Release: IDLE next cycle, req_ready = 1.
- Reset mid-operation: assert rst_n = 0 during READ1.
  - All outputs go to reset values immediately (asynchronously); no response is produced.
  - After release, the next request completes normally.
- Dedup: rs1 = rs2 = 6, with x6 preloaded to 0x55.
  - With REGSEQ_DEDUP_EN: one read, latency 2, both data = 0x55.
  - Without it: two reads, latency 3.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types and constants for the register-file initiator: sequencer state
// encoding, port operation codes and RV32I sizing defaults.
package regfile_pkg;

    localparam int DEF_XLEN   = 32;
    localparam int DEF_REG_AW = 5;

    localparam logic REG_READ  = 1'b0;
    localparam logic REG_WRITE = 1'b1;

    localparam logic [DEF_REG_AW-1:0] REG_ZERO = '0;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_READ1 = 3'd2,
        ST_READ2 = 3'd3,
        ST_RESP  = 3'd4
    } seq_state_t;

    // Earliest remaining step in the fixed order WRITE, READ1, READ2, RESP.
    function automatic seq_state_t first_step(input logic need_w,
                                              input logic need_r1,
                                              input logic need_r2);
        if (need_w)
            return ST_WRITE;
        else if (need_r1)
            return ST_READ1;
        else if (need_r2)
            return ST_READ2;
        else
            return ST_RESP;
    endfunction

endpackage

// File: rtl/regfile_access_sequencer.sv
// Serialises an optional rd writeback plus rs1/rs2 operand reads onto a single
// register-file port. Build option REGSEQ_DEDUP_EN merges identical rs1/rs2 reads.
//
// state  | meaning
// IDLE   | ready for a request; port idle
// WRITE  | writing wdata to rd (one cycle)
// READ1  | reading rs1 into the response register
// READ2  | reading rs2 into the response register
// RESP   | operands valid, held until rsp_ready
module regfile_access_sequencer
    import regfile_pkg::*;
#(
    parameter int XLEN   = DEF_XLEN,
    parameter int REG_AW = DEF_REG_AW
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [REG_AW-1:0] req_rd,
    input  logic [XLEN-1:0]   req_wdata,
    input  logic [REG_AW-1:0] req_rs1,
    input  logic [REG_AW-1:0] req_rs2,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [XLEN-1:0]   rsp_rs1_data,
    output logic [XLEN-1:0]   rsp_rs2_data,
    output logic [XLEN-1:0]   reg_address,
    output logic [XLEN-1:0]   reg_input,
    output logic              reg_operation,
    input  logic [XLEN-1:0]   reg_output
);

`ifdef REGSEQ_DEDUP_EN
    localparam logic DEDUP = 1'b1;
`else
    localparam logic DEDUP = 1'b0;
`endif

    localparam logic [REG_AW-1:0] IDX_ZERO = REG_ZERO[REG_AW-1:0];

    seq_state_t state, state_nxt;

    logic [REG_AW-1:0] rd_q, rs1_q, rs2_q;
    logic [XLEN-1:0]   wdata_q;
    logic              need_r1_q, need_r2_q, dup_q;

    logic accept;
    logic need_w, need_r1, need_r2, dup;

    assign accept  = req_valid && req_ready;
    assign need_w  = req_we && (req_rd != IDX_ZERO);
    assign need_r1 = (req_rs1 != IDX_ZERO);
    assign dup     = DEDUP && need_r1 && (req_rs1 == req_rs2);
    assign need_r2 = (req_rs2 != IDX_ZERO) && !dup;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (accept) state_nxt = first_step(need_w, need_r1, need_r2);
            ST_WRITE: state_nxt = first_step(1'b0, need_r1_q, need_r2_q);
            ST_READ1: state_nxt = first_step(1'b0, 1'b0, need_r2_q);
            ST_READ2: state_nxt = ST_RESP;
            ST_RESP:  if (rsp_ready) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Port drive decodes straight from state so reset idles the port at once.
    always_comb begin
        req_ready     = 1'b0;
        rsp_valid     = 1'b0;
        reg_address   = '0;
        reg_input     = '0;
        reg_operation = REG_READ;
        case (state)
            ST_IDLE:  req_ready = 1'b1;
            ST_WRITE: begin
                reg_address   = {{(XLEN-REG_AW){1'b0}}, rd_q};
                reg_input     = wdata_q;
                reg_operation = REG_WRITE;
            end
            ST_READ1: reg_address = {{(XLEN-REG_AW){1'b0}}, rs1_q};
            ST_READ2: reg_address = {{(XLEN-REG_AW){1'b0}}, rs2_q};
            ST_RESP:  rsp_valid = 1'b1;
            default:  req_ready = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q         <= '0;
            rs1_q        <= '0;
            rs2_q        <= '0;
            wdata_q      <= '0;
            need_r1_q    <= 1'b0;
            need_r2_q    <= 1'b0;
            dup_q        <= 1'b0;
            rsp_rs1_data <= '0;
            rsp_rs2_data <= '0;
        end else begin
            if (state == ST_IDLE && accept) begin
                rd_q         <= req_rd;
                rs1_q        <= req_rs1;
                rs2_q        <= req_rs2;
                wdata_q      <= req_wdata;
                need_r1_q    <= need_r1;
                need_r2_q    <= need_r2;
                dup_q        <= dup;
                // Skipped reads resolve to x0; required ones get overwritten.
                rsp_rs1_data <= '0;
                rsp_rs2_data <= '0;
            end
            if (state == ST_READ1) begin
                rsp_rs1_data <= reg_output;
                if (dup_q)
                    rsp_rs2_data <= reg_output;
            end
            if (state == ST_READ2)
                rsp_rs2_data <= reg_output;
        end
    end

endmodule

// File: tb/tb_regfile_access_sequencer.sv
// Directed bench for regfile_access_sequencer with a behavioural single-port
// register file; expectations for REGSEQ_DEDUP_EN follow the same macro.
module tb_regfile_access_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_we;
    logic [4:0]  req_rd, req_rs1, req_rs2;
    logic [31:0] req_wdata;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_rs1_data, rsp_rs2_data;
    logic [31:0] reg_address, reg_input, reg_output;
    logic        reg_operation;

    int vectors = 0;
    int errors  = 0;
    int read_cnt;
    logic saw_write;
    logic [31:0] rf [32];

    always #5 clk = ~clk;

    regfile_access_sequencer dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_rd(req_rd), .req_wdata(req_wdata), .req_rs1(req_rs1), .req_rs2(req_rs2),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rs1_data(rsp_rs1_data), .rsp_rs2_data(rsp_rs2_data),
        .reg_address(reg_address), .reg_input(reg_input),
        .reg_operation(reg_operation), .reg_output(reg_output)
    );

    assign reg_output = (reg_address[4:0] == 5'd0) ? 32'd0 : rf[reg_address[4:0]];

    always @(posedge clk)
        if (reg_operation === 1'b1 && reg_address[4:0] != 5'd0)
            rf[reg_address[4:0]] <= reg_input;

    always @(negedge clk) begin
        if (reg_operation === 1'b1) saw_write = 1'b1;
        if (rst_n && reg_operation === 1'b0 && reg_address != 32'd0) read_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic we, input logic [4:0] rd, input logic [31:0] wd,
                         input logic [4:0] rs1, input logic [4:0] rs2);
        req_valid = 1'b1;
        req_we    = we;
        req_rd    = rd;
        req_wdata = wd;
        req_rs1   = rs1;
        req_rs2   = rs2;
    endtask

    task automatic run_req(input string tag, input logic we, input logic [4:0] rd,
                           input logic [31:0] wd, input logic [4:0] rs1, input logic [4:0] rs2,
                           input int exp_lat, input logic [31:0] e1, input logic [31:0] e2);
        int lat;
        drive(we, rd, wd, rs1, rs2);
        chk({tag, "_ready"}, 32'(req_ready), 32'd1);
        step;
        req_valid = 1'b0;
        lat = 1;
        while (rsp_valid !== 1'b1 && lat < 8) begin
            step;
            lat++;
        end
        chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_rs1"}, rsp_rs1_data, e1);
        chk({tag, "_rs2"}, rsp_rs2_data, e2);
        rsp_ready = 1'b1;
        step;
        rsp_ready = 1'b0;
        chk({tag, "_idle_ready"}, 32'(req_ready), 32'd1);
        chk({tag, "_idle_valid"}, 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_rd = '0; req_wdata = '0;
        req_rs1 = '0; req_rs2 = '0; rsp_ready = 1'b0;
        saw_write = 1'b0; read_cnt = 0;
        for (int i = 0; i < 32; i++) rf[i] = 32'd0;
        rf[3] = 32'd7;
        rf[4] = 32'd9;
        rf[6] = 32'h55;

        step; step;
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rs1_data", rsp_rs1_data, 32'd0);
        chk("rst_rs2_data", rsp_rs2_data, 32'd0);
        chk("rst_address", reg_address, 32'd0);
        chk("rst_operation", 32'(reg_operation), 32'd0);
        chk("rst_input", reg_input, 32'd0);
        rst_n = 1'b1;
        step;

        // Write x5 then read it back in the same request.
        drive(1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd0);
        step;
        req_valid = 1'b0;
        chk("wr_address", reg_address, 32'd5);
        chk("wr_operation", 32'(reg_operation), 32'd1);
        chk("wr_input", reg_input, 32'hDEADBEEF);
        chk("wr_req_ready", 32'(req_ready), 32'd0);
        step;
        chk("rd1_address", reg_address, 32'd5);
        chk("rd1_operation", 32'(reg_operation), 32'd0);
        chk("rd1_input", reg_input, 32'd0);
        chk("rd1_rsp_valid", 32'(rsp_valid), 32'd0);
        step;
        chk("wb_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("wb_rs1", rsp_rs1_data, 32'hDEADBEEF);
        chk("wb_rs2", rsp_rs2_data, 32'd0);
        chk("wb_resp_address", reg_address, 32'd0);
        rsp_ready = 1'b1;
        step;
        rsp_ready = 1'b0;
        chk("wb_back_idle", 32'(req_ready), 32'd1);

        // Write to x0 is dropped; nothing touches the port.
        saw_write = 1'b0;
        read_cnt = 0;
        run_req("x0", 1'b1, 5'd0, 32'h1234, 5'd0, 5'd0, 1, 32'd0, 32'd0);
        chk("x0_no_write", 32'(saw_write), 32'd0);
        chk("x0_no_read", 32'(read_cnt), 32'd0);

        // Two distinct reads followed by five cycles of response backpressure.
        drive(1'b0, 5'd0, 32'd0, 5'd3, 5'd4);
        step;
        req_valid = 1'b0;
        chk("rr_addr1", reg_address, 32'd3);
        step;
        chk("rr_addr2", reg_address, 32'd4);
        chk("rr_op2", 32'(reg_operation), 32'd0);
        step;
        drive(1'b1, 5'd8, 32'hAAAA, 5'd0, 5'd0);
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_rs1", rsp_rs1_data, 32'd7);
            chk("bp_rs2", rsp_rs2_data, 32'd9);
            chk("bp_req_ready", 32'(req_ready), 32'd0);
            step;
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        step;
        rsp_ready = 1'b0;
        chk("bp_release_ready", 32'(req_ready), 32'd1);
        chk("bp_release_valid", 32'(rsp_valid), 32'd0);
        chk("bp_no_accept", rf[8], 32'd0);

        // Longest path: write, then two reads, one of them of the fresh rd.
        run_req("max", 1'b1, 5'd7, 32'hCAFE0001, 5'd7, 5'd3, 4, 32'hCAFE0001, 32'd7);

        // Identical operands.
        read_cnt = 0;
`ifdef REGSEQ_DEDUP_EN
        run_req("dedup", 1'b0, 5'd0, 32'd0, 5'd6, 5'd6, 2, 32'h55, 32'h55);
        chk("dedup_reads", 32'(read_cnt), 32'd1);
`else
        run_req("dedup", 1'b0, 5'd0, 32'd0, 5'd6, 5'd6, 3, 32'h55, 32'h55);
        chk("dedup_reads", 32'(read_cnt), 32'd2);
`endif

        // Asynchronous reset during READ1.
        drive(1'b0, 5'd0, 32'd0, 5'd3, 5'd4);
        step;
        req_valid = 1'b0;
        chk("mid_pre_addr", reg_address, 32'd3);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_address", reg_address, 32'd0);
        chk("mid_rst_operation", 32'(reg_operation), 32'd0);
        chk("mid_rst_req_ready", 32'(req_ready), 32'd1);
        chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("mid_rst_rs1", rsp_rs1_data, 32'd0);
        #3 rst_n = 1'b1;

        // Asynchronous reset during WRITE drops the write strobe at once.
        step;
        drive(1'b1, 5'd10, 32'h77, 5'd0, 5'd0);
        step;
        req_valid = 1'b0;
        chk("wrst_pre_op", 32'(reg_operation), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("wrst_operation", 32'(reg_operation), 32'd0);
        chk("wrst_input", reg_input, 32'd0);
        #3 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step;
            chk("post_rst_no_rsp", 32'(rsp_valid), 32'd0);
        end
        run_req("post_rst", 1'b0, 5'd0, 32'd0, 5'd4, 5'd3, 3, 32'd9, 32'd7);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
